multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Adds a memory ready handshake with timeout, a multi-cycle multiply stall, and the full R/I/branch/jump set (sll/srl/and/or/xor/nor, andi/xori/slti, lb/lh/lw, sb/sh/sw, beq/bne/bgez/bltz/bgtz/blez, j/jal/jr).
- Sits between the instruction register and the shared datapath.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles a mul occupies when the stall feature is compiled in (minimum 1).
- MEM_TIMEOUT, 15, maximum MEM-state cycles to wait for MemReady before aborting.
- CNT_W, 4, width of the internal cycle counter; must hold max(MUL_CYCLES, MEM_TIMEOUT).

Ports:
- Clk input 1 system clock, rising edge.
- Reset input 1 synchronous, active-high.
- Instruction input 32 instruction register contents; stable from DECODE through WB.
- BranchOutput input 1 branch comparator result for the current branch.
- MemReady input 1 data memory has completed the access this cycle.
- IRWrite output 1 load the instruction register.
- PCWrite output 1 update the PC.
- RegWrite output 1 register file write enable.
- ALUSrc output 1 selects the ALU B operand: 1 = immediate.
- RegDst output 1 selects the destination register: 1 = rd, 0 = rt.
- MemToReg output 1 selects write-back data: 1 = ALU result, 0 = memory data.
- Jump, Jal, Jr output 1 each jump-target selects.
- ShiftControl output 1 selects shamt as the ALU A operand.
- PCSrc output 1 selects the branch target.
- MemWrite output 2 store size: 00 none, 01 word, 10 half, 11 byte.
- MemRead output 2 load size, same encoding as MemWrite.
- ALUControl output 5 ALU operation code.
- IllegalOp output 1 sticky flag for an unknown opcode or funct.
- MemFault output 1 sticky flag for a memory timeout.
- StateOut output 3 current state, for debug.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset state: state = FETCH, counter = 0, IllegalOp = 0, MemFault = 0.
- Reset outputs: all control outputs 0 and ALUControl = 11111.
- Reset mid-operation: any in-flight access is abandoned with no write or PC update. The first post-reset cycle is FETCH.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Output style: outputs are Moore decodes of the state plus the opcode/funct/rt latched on DECODE entry. The exception is PCSrc, which is Mealy on BranchOutput in EXEC.
- FETCH: IRWrite=1, PCWrite=1 (PC+4). Next state DECODE.
- DECODE: latch the fields; no enables asserted.
  - Unknown opcode or funct: set IllegalOp, next state FETCH.
  - Otherwise: next state EXEC.
- EXEC, ALU codes: add/addi/lw/lb/lh/sw/sb/sh 00001, sub 00010, mul 00011, sll 00100, srl 00101, and/andi 00110, or/ori 00111, xor/xori 01000, nor 01101, slt/slti 01110, branch/jump 11111.
- EXEC, ALUSrc and ShiftControl: ALUSrc=1 for I-type ALU ops and memory ops. ShiftControl=1 for sll/srl.
- EXEC, branches: PCSrc = PCWrite = BranchOutput for one cycle. Next state FETCH.
- EXEC, j: Jump=1, PCWrite=1. Next state FETCH.
- EXEC, jr: Jr=1, PCWrite=1. Next state FETCH.
- EXEC, jal: Jump=1, Jal=1, PCWrite=1, RegWrite=1 (writes $31). Next state FETCH.
- EXEC, next state for the rest: memory ops go to MEM; other ALU ops go to WB.
- MEM: MemRead/MemWrite held at the size code and ALUControl held at 00001. The counter increments each cycle; the cycle-1 counter value is 0.
  - MemReady=1: loads go to WB, stores go to FETCH.
  - Counter reaches MEM_TIMEOUT without MemReady: set MemFault, deassert, go to FETCH, no write.
  - MemReady on the timeout cycle: MemReady wins.
- WB: RegWrite=1 for one cycle. RegDst=1 for R-type and mul. MemToReg=0 for loads, 1 otherwise. Next state FETCH.
- Invariant: RegWrite, MemWrite, and PCWrite are never asserted in the same cycle, except that jal asserts RegWrite and PCWrite together.
- Latency (EXEC with no stall, MemReady on the first MEM cycle):
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump: 3 cycles.

Optional Feature:
- Macro: MULDIV_STALL_EN.
- Defined: mul stays in EXEC for MUL_CYCLES cycles, with ALUControl held at 00011, then goes to WB. Counter is cleared on EXEC entry.
- Undefined: mul uses a single EXEC cycle, MUL_CYCLES is ignored, and the stall counter logic is absent.

Decomposition:
- Package controller_pkg holds:
  - opcode constants, funct constants, and the REGIMM rt codes;
  - ALUControl codes;
  - state encoding;
  - mem size encoding.
- Sub-module alu_decode: combinational mapping of opcode, funct to ALUControl, ALUSrc, ShiftControl, and legality.

Test Plan:
- add (opcode 0, funct 100000), Reset released → FETCH, DECODE, EXEC (ALUControl=00001), WB (RegWrite=1, RegDst=1, MemToReg=1), then FETCH; 4 cycles total.
- lw with MemReady asserted on the 3rd MEM cycle → MemRead=01 held for 3 cycles, then WB with MemToReg=0; sb → MemWrite=11, returns to FETCH with no WB.
- bne with BranchOutput=1, then with BranchOutput=0 → PCSrc=PCWrite=1 in EXEC for one cycle; in the second case both stay 0; FETCH follows in both.
- sw with MemReady held at 0 and MEM_TIMEOUT=15 → MemFault=1 after 15 MEM cycles, returns to FETCH, MemWrite=00, no RegWrite.
- mul with MULDIV_STALL_EN defined and MUL_CYCLES=4 → 4 EXEC cycles with ALUControl=00011, then WB; undefined → 1 EXEC cycle.
- Opcode 111111 → IllegalOp=1 after DECODE, returns to FETCH; Reset asserted during MEM → next cycle is FETCH, flags clear, no write.

Source files
------------

// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controller_pkg
//  Description : Shared constants for the multi-cycle MIPS controller:
//                opcode / funct / REGIMM rt codes, ALUControl codes, state
//                encoding, memory access size encoding and the internal
//                instruction class codes produced by alu_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package controller_pkg;

    // ---------------------------------------------------------------- states
    typedef logic [2:0] state_t;
    localparam state_t c_st_fetch  = 3'd0;
    localparam state_t c_st_decode = 3'd1;
    localparam state_t c_st_exec   = 3'd2;
    localparam state_t c_st_mem    = 3'd3;
    localparam state_t c_st_wb     = 3'd4;

    // --------------------------------------------------------------- opcodes
    localparam logic [5:0] c_op_rtype    = 6'b000000;
    localparam logic [5:0] c_op_regimm   = 6'b000001;
    localparam logic [5:0] c_op_j        = 6'b000010;
    localparam logic [5:0] c_op_jal      = 6'b000011;
    localparam logic [5:0] c_op_beq      = 6'b000100;
    localparam logic [5:0] c_op_bne      = 6'b000101;
    localparam logic [5:0] c_op_blez     = 6'b000110;
    localparam logic [5:0] c_op_bgtz     = 6'b000111;
    localparam logic [5:0] c_op_addi     = 6'b001000;
    localparam logic [5:0] c_op_slti     = 6'b001010;
    localparam logic [5:0] c_op_andi     = 6'b001100;
    localparam logic [5:0] c_op_ori      = 6'b001101;
    localparam logic [5:0] c_op_xori     = 6'b001110;
    localparam logic [5:0] c_op_special2 = 6'b011100;
    localparam logic [5:0] c_op_lb       = 6'b100000;
    localparam logic [5:0] c_op_lh       = 6'b100001;
    localparam logic [5:0] c_op_lw       = 6'b100011;
    localparam logic [5:0] c_op_sb       = 6'b101000;
    localparam logic [5:0] c_op_sh       = 6'b101001;
    localparam logic [5:0] c_op_sw       = 6'b101011;

    // ---------------------------------------------------------------- functs
    localparam logic [5:0] c_fn_sll = 6'b000000;
    localparam logic [5:0] c_fn_srl = 6'b000010;
    localparam logic [5:0] c_fn_jr  = 6'b001000;
    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_xor = 6'b100110;
    localparam logic [5:0] c_fn_nor = 6'b100111;
    localparam logic [5:0] c_fn_slt = 6'b101010;
    // funct of mul under the SPECIAL2 opcode
    localparam logic [5:0] c_fn_mul = 6'b000010;

    // ------------------------------------------------------- REGIMM rt codes
    localparam logic [4:0] c_rt_bltz = 5'b00000;
    localparam logic [4:0] c_rt_bgez = 5'b00001;

    // ----------------------------------------------------- ALUControl codes
    localparam logic [4:0] c_alu_add  = 5'b00001;
    localparam logic [4:0] c_alu_sub  = 5'b00010;
    localparam logic [4:0] c_alu_mul  = 5'b00011;
    localparam logic [4:0] c_alu_sll  = 5'b00100;
    localparam logic [4:0] c_alu_srl  = 5'b00101;
    localparam logic [4:0] c_alu_and  = 5'b00110;
    localparam logic [4:0] c_alu_or   = 5'b00111;
    localparam logic [4:0] c_alu_xor  = 5'b01000;
    localparam logic [4:0] c_alu_nor  = 5'b01101;
    localparam logic [4:0] c_alu_slt  = 5'b01110;
    localparam logic [4:0] c_alu_none = 5'b11111;

    // ------------------------------------------------- memory access sizes
    localparam logic [1:0] c_sz_none = 2'b00;
    localparam logic [1:0] c_sz_word = 2'b01;
    localparam logic [1:0] c_sz_half = 2'b10;
    localparam logic [1:0] c_sz_byte = 2'b11;

    // --------------------------------------------------- instruction class
    typedef logic [3:0] iclass_t;
    localparam iclass_t c_cls_none   = 4'd0;
    localparam iclass_t c_cls_ralu   = 4'd1;  // R-type ALU op, writes rd
    localparam iclass_t c_cls_ialu   = 4'd2;  // I-type ALU op, writes rt
    localparam iclass_t c_cls_mul    = 4'd3;
    localparam iclass_t c_cls_load   = 4'd4;
    localparam iclass_t c_cls_store  = 4'd5;
    localparam iclass_t c_cls_branch = 4'd6;
    localparam iclass_t c_cls_j      = 4'd7;
    localparam iclass_t c_cls_jal    = 4'd8;
    localparam iclass_t c_cls_jr     = 4'd9;

    // Access size of a load/store opcode; c_sz_none for anything else.
    function automatic logic [1:0] mem_size(input logic [5:0] opcode);
        logic [1:0] sz;
        case (opcode)
            c_op_lw, c_op_sw: sz = c_sz_word;
            c_op_lh, c_op_sh: sz = c_sz_half;
            c_op_lb, c_op_sb: sz = c_sz_byte;
            default:          sz = c_sz_none;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode
//  Description : Combinational decode of opcode / funct / rt into the ALU
//                operation, operand selects, instruction class and legality.
//  Ports       : i_opcode   [5:0] instruction opcode field
//                i_funct    [5:0] instruction funct field
//                i_rt       [4:0] rt field (selects REGIMM branch kind)
//                o_alu_ctl  [4:0] ALUControl code
//                o_alu_src        ALU B operand is the immediate
//                o_shift          ALU A operand is shamt
//                o_iclass   [3:0] instruction class
//                o_legal          opcode/funct combination is implemented
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import controller_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    output logic [4:0] o_alu_ctl,
    output logic       o_alu_src,
    output logic       o_shift,
    output iclass_t    o_iclass,
    output logic       o_legal
);

    always_comb begin
        o_alu_ctl = c_alu_none;
        o_alu_src = 1'b0;
        o_shift   = 1'b0;
        o_iclass  = c_cls_none;
        o_legal   = 1'b1;

        case (i_opcode)
            c_op_rtype: begin
                o_iclass = c_cls_ralu;
                case (i_funct)
                    c_fn_add: o_alu_ctl = c_alu_add;
                    c_fn_sub: o_alu_ctl = c_alu_sub;
                    c_fn_and: o_alu_ctl = c_alu_and;
                    c_fn_or:  o_alu_ctl = c_alu_or;
                    c_fn_xor: o_alu_ctl = c_alu_xor;
                    c_fn_nor: o_alu_ctl = c_alu_nor;
                    c_fn_slt: o_alu_ctl = c_alu_slt;
                    c_fn_sll: begin
                        o_alu_ctl = c_alu_sll;
                        o_shift   = 1'b1;
                    end
                    c_fn_srl: begin
                        o_alu_ctl = c_alu_srl;
                        o_shift   = 1'b1;
                    end
                    c_fn_jr:  o_iclass = c_cls_jr;
                    default: begin
                        o_iclass = c_cls_none;
                        o_legal  = 1'b0;
                    end
                endcase
            end
            c_op_special2: begin
                if (i_funct == c_fn_mul) begin
                    o_iclass  = c_cls_mul;
                    o_alu_ctl = c_alu_mul;
                end else begin
                    o_legal = 1'b0;
                end
            end
            c_op_addi, c_op_slti, c_op_andi, c_op_ori, c_op_xori: begin
                o_iclass  = c_cls_ialu;
                o_alu_src = 1'b1;
                case (i_opcode)
                    c_op_addi: o_alu_ctl = c_alu_add;
                    c_op_slti: o_alu_ctl = c_alu_slt;
                    c_op_andi: o_alu_ctl = c_alu_and;
                    c_op_ori:  o_alu_ctl = c_alu_or;
                    default:   o_alu_ctl = c_alu_xor;
                endcase
            end
            c_op_lb, c_op_lh, c_op_lw: begin
                o_iclass  = c_cls_load;
                o_alu_ctl = c_alu_add;
                o_alu_src = 1'b1;
            end
            c_op_sb, c_op_sh, c_op_sw: begin
                o_iclass  = c_cls_store;
                o_alu_ctl = c_alu_add;
                o_alu_src = 1'b1;
            end
            c_op_beq, c_op_bne, c_op_blez, c_op_bgtz: o_iclass = c_cls_branch;
            c_op_regimm: begin
                if (i_rt == c_rt_bltz || i_rt == c_rt_bgez) begin
                    o_iclass = c_cls_branch;
                end else begin
                    o_legal = 1'b0;
                end
            end
            c_op_j:   o_iclass = c_cls_j;
            c_op_jal: o_iclass = c_cls_jal;
            default:  o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multi-cycle MIPS control unit. Steps each instruction
//                through FETCH / DECODE / EXEC / MEM / WB and drives the
//                shared datapath selects and enables. Includes a memory
//                ready handshake with timeout and sticky error flags.
//  Options     : MULDIV_STALL_EN - when defined, mul holds EXEC for
//                MUL_CYCLES cycles; otherwise mul takes one EXEC cycle.
//  Ports       : Clk, Reset (sync, active-high)
//                Instruction[31:0]  IR contents, stable DECODE..WB
//                BranchOutput       branch comparator result
//                MemReady           data memory finished this cycle
//                IRWrite, PCWrite, RegWrite, ALUSrc, RegDst, MemToReg,
//                Jump, Jal, Jr, ShiftControl, PCSrc   datapath controls
//                MemWrite[1:0], MemRead[1:0]  access size (00 = none)
//                ALUControl[4:0]    ALU operation
//                IllegalOp, MemFault sticky error flags
//                StateOut[2:0]      current state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        BranchOutput,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        Jump,
    output logic        Jal,
    output logic        Jr,
    output logic        ShiftControl,
    output logic        PCSrc,
    output logic [1:0]  MemWrite,
    output logic [1:0]  MemRead,
    output logic [4:0]  ALUControl,
    output logic        IllegalOp,
    output logic        MemFault,
    output logic [2:0]  StateOut
);

    // Last MEM cycle index before a timeout abort (first MEM cycle is 0).
    localparam logic [CNT_W-1:0] c_mem_last = CNT_W'(MEM_TIMEOUT - 1);
`ifdef MULDIV_STALL_EN
    localparam logic [CNT_W-1:0] c_mul_last = CNT_W'(MUL_CYCLES - 1);
`else
    localparam int c_unused_mul_cycles = MUL_CYCLES;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mem_timeout;

    // Decoded view of the instruction held for EXEC..WB
    iclass_t          r_cls;
    logic [4:0]       r_alu_ctl;
    logic             r_alu_src;
    logic             r_shift;
    logic [1:0]       r_msize;

    logic             r_illegal;
    logic             r_memfault;

    logic [4:0]       w_dec_alu_ctl;
    logic             w_dec_alu_src;
    logic             w_dec_shift;
    iclass_t          w_dec_cls;
    logic             w_dec_legal;

    // rs, rd, shamt and immediate bits belong to the datapath only
    logic             w_unused_instr;
    assign w_unused_instr = ^{Instruction[25:21], Instruction[15:6]};

    alu_decode u_alu_decode (
        .i_opcode  (Instruction[31:26]),
        .i_funct   (Instruction[5:0]),
        .i_rt      (Instruction[20:16]),
        .o_alu_ctl (w_dec_alu_ctl),
        .o_alu_src (w_dec_alu_src),
        .o_shift   (w_dec_shift),
        .o_iclass  (w_dec_cls),
        .o_legal   (w_dec_legal)
    );

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next        = r_state;
        w_mem_timeout = 1'b0;
        case (r_state)
            c_st_fetch:  w_next = c_st_decode;
            c_st_decode: w_next = w_dec_legal ? c_st_exec : c_st_fetch;
            c_st_exec: begin
                case (r_cls)
                    c_cls_load, c_cls_store: w_next = c_st_mem;
                    c_cls_ralu, c_cls_ialu:  w_next = c_st_wb;
`ifdef MULDIV_STALL_EN
                    c_cls_mul: w_next = (r_cnt == c_mul_last) ? c_st_wb : c_st_exec;
`else
                    c_cls_mul: w_next = c_st_wb;
`endif
                    default: w_next = c_st_fetch;
                endcase
            end
            c_st_mem: begin
                // MemReady takes priority over a timeout on the same cycle
                if (MemReady) begin
                    w_next = (r_cls == c_cls_load) ? c_st_wb : c_st_fetch;
                end else if (r_cnt == c_mem_last) begin
                    w_next        = c_st_fetch;
                    w_mem_timeout = 1'b1;
                end
            end
            c_st_wb:  w_next = c_st_fetch;
            default:  w_next = c_st_fetch;
        endcase
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_st_fetch;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // The counter only runs while a state repeats (MEM wait or
            // mul stall), so clearing on every transition covers entry.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Capture happens at the end of DECODE: the IR itself is loaded on the
    // FETCH->DECODE edge, so DECODE is the first cycle the fields are valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cls     <= c_cls_none;
            r_alu_ctl <= c_alu_none;
            r_alu_src <= 1'b0;
            r_shift   <= 1'b0;
            r_msize   <= c_sz_none;
        end else if (r_state == c_st_decode) begin
            r_cls     <= w_dec_cls;
            r_alu_ctl <= w_dec_alu_ctl;
            r_alu_src <= w_dec_alu_src;
            r_shift   <= w_dec_shift;
            r_msize   <= mem_size(Instruction[31:26]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_illegal  <= 1'b0;
            r_memfault <= 1'b0;
        end else begin
            if (r_state == c_st_decode && !w_dec_legal) begin
                r_illegal <= 1'b1;
            end
            if (w_mem_timeout) begin
                r_memfault <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // While Reset is high every control is forced idle so an access that
    // is cut short never writes memory, the register file or the PC.
    always_comb begin
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrc       = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        Jump         = 1'b0;
        Jal          = 1'b0;
        Jr           = 1'b0;
        ShiftControl = 1'b0;
        PCSrc        = 1'b0;
        MemWrite     = c_sz_none;
        MemRead      = c_sz_none;
        ALUControl   = c_alu_none;

        if (!Reset) begin
            case (r_state)
                c_st_fetch: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                c_st_exec: begin
                    ALUControl   = r_alu_ctl;
                    ALUSrc       = r_alu_src;
                    ShiftControl = r_shift;
                    case (r_cls)
                        c_cls_branch: begin
                            PCSrc   = BranchOutput;
                            PCWrite = BranchOutput;
                        end
                        c_cls_j: begin
                            Jump    = 1'b1;
                            PCWrite = 1'b1;
                        end
                        c_cls_jr: begin
                            Jr      = 1'b1;
                            PCWrite = 1'b1;
                        end
                        c_cls_jal: begin
                            Jump     = 1'b1;
                            Jal      = 1'b1;
                            PCWrite  = 1'b1;
                            RegWrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_st_mem: begin
                    ALUControl = c_alu_add;
                    ALUSrc     = 1'b1;
                    if (r_cls == c_cls_load) begin
                        MemRead = r_msize;
                    end else begin
                        MemWrite = r_msize;
                    end
                end
                c_st_wb: begin
                    RegWrite     = 1'b1;
                    RegDst       = (r_cls == c_cls_ralu) || (r_cls == c_cls_mul);
                    MemToReg     = (r_cls != c_cls_load);
                    ALUControl   = r_alu_ctl;
                    ALUSrc       = r_alu_src;
                    ShiftControl = r_shift;
                end
                default: ;
            endcase
        end
    end

    assign IllegalOp = r_illegal;
    assign MemFault  = r_memfault;
    assign StateOut  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. A table of
//                the instruction set drives a cycle-by-cycle trace model of
//                the expected control outputs; directed and random
//                instructions are compared against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int MUL_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 15;
`ifdef MULDIV_STALL_EN
    localparam int EXP_MUL = MUL_CYCLES;
`else
    localparam int EXP_MUL = 1;
`endif

    localparam int K_R = 0, K_I = 1, K_MUL = 2, K_LD = 3, K_ST = 4;
    localparam int K_BR = 5, K_J = 6, K_JAL = 7, K_JR = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instruction = '0;
    logic        BranchOutput = 1'b0;
    logic        MemReady = 1'b0;
    logic        IRWrite, PCWrite, RegWrite, ALUSrc, RegDst, MemToReg;
    logic        Jump, Jal, Jr, ShiftControl, PCSrc, IllegalOp, MemFault;
    logic [1:0]  MemWrite, MemRead;
    logic [4:0]  ALUControl;
    logic [2:0]  StateOut;

    multicycle_controller #(
        .MUL_CYCLES  (MUL_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instruction  (Instruction),
        .BranchOutput (BranchOutput),
        .MemReady     (MemReady),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .ALUSrc       (ALUSrc),
        .RegDst       (RegDst),
        .MemToReg     (MemToReg),
        .Jump         (Jump),
        .Jal          (Jal),
        .Jr           (Jr),
        .ShiftControl (ShiftControl),
        .PCSrc        (PCSrc),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ALUControl   (ALUControl),
        .IllegalOp    (IllegalOp),
        .MemFault     (MemFault),
        .StateOut     (StateOut)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] st;
        logic       irw, pcw, rw;
        logic [1:0] mw, mr;
        logic       pcsrc, j, jal, jr;
        logic [4:0] alu;
        logic       asrc, sh, rdst, m2r, ill, mf;
    } obs_t;

    typedef struct packed {
        obs_t e;    // expected values
        obs_t m;    // which bits are defined for this cycle
        logic rdy;  // MemReady to drive during this cycle
    } step_t;

    typedef struct {
        logic [5:0] op;
        int         fsel;   // 0: opcode only, 1: funct must match, 2: rt must match
        logic [5:0] fn;
        logic [4:0] rt;
        int         kind;
        logic [4:0] alu;
        bit         isrc;
        bit         sh;
        logic [1:0] sz;
    } ent_t;

    ent_t  tbl[$];
    step_t q[$];
    int    total = 0;
    int    bad = 0;
    bit    ill_m = 1'b0;
    bit    mf_m = 1'b0;

    function automatic void add_e(logic [5:0] op, int fsel, logic [5:0] fn, logic [4:0] rt,
                                  int kind, logic [4:0] alu, bit isrc, bit sh, logic [1:0] sz);
        ent_t e;
        e = '{op, fsel, fn, rt, kind, alu, isrc, sh, sz};
        tbl.push_back(e);
    endfunction

    task automatic init_table();
        add_e(6'h00, 1, 6'b100000, 5'd0, K_R,  5'b00001, 0, 0, 2'b00); // add
        add_e(6'h00, 1, 6'b100010, 5'd0, K_R,  5'b00010, 0, 0, 2'b00); // sub
        add_e(6'h00, 1, 6'b100100, 5'd0, K_R,  5'b00110, 0, 0, 2'b00); // and
        add_e(6'h00, 1, 6'b100101, 5'd0, K_R,  5'b00111, 0, 0, 2'b00); // or
        add_e(6'h00, 1, 6'b100110, 5'd0, K_R,  5'b01000, 0, 0, 2'b00); // xor
        add_e(6'h00, 1, 6'b100111, 5'd0, K_R,  5'b01101, 0, 0, 2'b00); // nor
        add_e(6'h00, 1, 6'b101010, 5'd0, K_R,  5'b01110, 0, 0, 2'b00); // slt
        add_e(6'h00, 1, 6'b000000, 5'd0, K_R,  5'b00100, 0, 1, 2'b00); // sll
        add_e(6'h00, 1, 6'b000010, 5'd0, K_R,  5'b00101, 0, 1, 2'b00); // srl
        add_e(6'h00, 1, 6'b001000, 5'd0, K_JR, 5'b11111, 0, 0, 2'b00); // jr
        add_e(6'h1c, 1, 6'b000010, 5'd0, K_MUL,5'b00011, 0, 0, 2'b00); // mul
        add_e(6'h08, 0, 6'd0, 5'd0, K_I,  5'b00001, 1, 0, 2'b00);      // addi
        add_e(6'h0a, 0, 6'd0, 5'd0, K_I,  5'b01110, 1, 0, 2'b00);      // slti
        add_e(6'h0c, 0, 6'd0, 5'd0, K_I,  5'b00110, 1, 0, 2'b00);      // andi
        add_e(6'h0d, 0, 6'd0, 5'd0, K_I,  5'b00111, 1, 0, 2'b00);      // ori
        add_e(6'h0e, 0, 6'd0, 5'd0, K_I,  5'b01000, 1, 0, 2'b00);      // xori
        add_e(6'h20, 0, 6'd0, 5'd0, K_LD, 5'b00001, 1, 0, 2'b11);      // lb
        add_e(6'h21, 0, 6'd0, 5'd0, K_LD, 5'b00001, 1, 0, 2'b10);      // lh
        add_e(6'h23, 0, 6'd0, 5'd0, K_LD, 5'b00001, 1, 0, 2'b01);      // lw
        add_e(6'h28, 0, 6'd0, 5'd0, K_ST, 5'b00001, 1, 0, 2'b11);      // sb
        add_e(6'h29, 0, 6'd0, 5'd0, K_ST, 5'b00001, 1, 0, 2'b10);      // sh
        add_e(6'h2b, 0, 6'd0, 5'd0, K_ST, 5'b00001, 1, 0, 2'b01);      // sw
        add_e(6'h04, 0, 6'd0, 5'd0, K_BR, 5'b11111, 0, 0, 2'b00);      // beq
        add_e(6'h05, 0, 6'd0, 5'd0, K_BR, 5'b11111, 0, 0, 2'b00);      // bne
        add_e(6'h06, 0, 6'd0, 5'd0, K_BR, 5'b11111, 0, 0, 2'b00);      // blez
        add_e(6'h07, 0, 6'd0, 5'd0, K_BR, 5'b11111, 0, 0, 2'b00);      // bgtz
        add_e(6'h01, 2, 6'd0, 5'd0, K_BR, 5'b11111, 0, 0, 2'b00);      // bltz
        add_e(6'h01, 2, 6'd0, 5'd1, K_BR, 5'b11111, 0, 0, 2'b00);      // bgez
        add_e(6'h02, 0, 6'd0, 5'd0, K_J,  5'b11111, 0, 0, 2'b00);      // j
        add_e(6'h03, 0, 6'd0, 5'd0, K_JAL,5'b11111, 0, 0, 2'b00);      // jal
    endtask

    function automatic int find(logic [31:0] ins);
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].op == ins[31:26] &&
                (tbl[k].fsel == 0 ||
                 (tbl[k].fsel == 1 && tbl[k].fn == ins[5:0]) ||
                 (tbl[k].fsel == 2 && tbl[k].rt == ins[20:16])))
                return k;
        end
        return -1;
    endfunction

    function automatic step_t new_step(logic [2:0] st);
        step_t s;
        s.e      = '0;
        s.e.st   = st;
        s.e.alu  = 5'b11111;
        s.e.ill  = ill_m;
        s.e.mf   = mf_m;
        s.m      = '1;
        s.m.alu  = '0;
        s.m.asrc = 1'b0;
        s.m.sh   = 1'b0;
        s.m.rdst = 1'b0;
        s.m.m2r  = 1'b0;
        s.rdy    = 1'b0;
        return s;
    endfunction

    // Expected trace of one instruction; rdy_at is the MEM cycle index on
    // which MemReady is given (>= MEM_TIMEOUT means never).
    task automatic build(input logic [31:0] ins, input bit br, input int rdy_at);
        step_t s;
        ent_t  t;
        int    idx;
        int    nmem;
        bit    done_ok;
        idx = find(ins);
        s = new_step(3'd0); s.e.irw = 1'b1; s.e.pcw = 1'b1; q.push_back(s);
        s = new_step(3'd1); q.push_back(s);
        if (idx < 0) begin
            ill_m = 1'b1;
            return;
        end
        t = tbl[idx];
        for (int k = 0; k < ((t.kind == K_MUL) ? EXP_MUL : 1); k++) begin
            s = new_step(3'd2);
            s.m.alu = '1; s.m.asrc = 1'b1; s.m.sh = 1'b1;
            s.e.alu = t.alu; s.e.asrc = t.isrc; s.e.sh = t.sh;
            case (t.kind)
                K_BR:  begin s.e.pcsrc = br; s.e.pcw = br; end
                K_J:   begin s.e.j = 1'b1; s.e.pcw = 1'b1; end
                K_JR:  begin s.e.jr = 1'b1; s.e.pcw = 1'b1; end
                K_JAL: begin s.e.j = 1'b1; s.e.jal = 1'b1; s.e.pcw = 1'b1; s.e.rw = 1'b1; end
                default: ;
            endcase
            q.push_back(s);
        end
        if (t.kind == K_BR || t.kind == K_J || t.kind == K_JR || t.kind == K_JAL)
            return;
        done_ok = 1'b1;
        if (t.kind == K_LD || t.kind == K_ST) begin
            done_ok = (rdy_at < MEM_TIMEOUT);
            nmem = done_ok ? rdy_at + 1 : MEM_TIMEOUT;
            for (int k = 0; k < nmem; k++) begin
                s = new_step(3'd3);
                s.m.alu = '1; s.e.alu = 5'b00001;
                if (t.kind == K_LD) s.e.mr = t.sz; else s.e.mw = t.sz;
                s.rdy = (k == rdy_at);
                q.push_back(s);
            end
            if (!done_ok) mf_m = 1'b1;
            if (t.kind == K_ST || !done_ok) return;
        end
        s = new_step(3'd4);
        s.m.rdst = 1'b1; s.m.m2r = 1'b1;
        s.e.rw   = 1'b1;
        s.e.rdst = (t.kind == K_R || t.kind == K_MUL);
        s.e.m2r  = (t.kind != K_LD);
        q.push_back(s);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = StateOut; o.irw = IRWrite; o.pcw = PCWrite; o.rw = RegWrite;
        o.mw = MemWrite; o.mr = MemRead; o.pcsrc = PCSrc; o.j = Jump;
        o.jal = Jal; o.jr = Jr; o.alu = ALUControl; o.asrc = ALUSrc;
        o.sh = ShiftControl; o.rdst = RegDst; o.m2r = MemToReg;
        o.ill = IllegalOp; o.mf = MemFault;
        return o;
    endfunction

    // Plays q cycle by cycle; entered and left at posedge+1.
    task automatic play(input string name, input int max_cyc);
        obs_t o;
        int   n;
        n = (max_cyc > 0 && max_cyc < q.size()) ? max_cyc : q.size();
        for (int i = 0; i < n; i++) begin
            MemReady = q[i].rdy;
            @(negedge Clk);
            o = sample();
            total++;
            if ((o & q[i].m) !== (q[i].e & q[i].m)) begin
                bad++;
                $display("FAIL %s cycle %0d: got=%h want=%h care=%h", name, i, o, q[i].e, q[i].m);
            end
            @(posedge Clk); #1;
        end
        MemReady = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] ins, input bit br,
                       input int rdy_at, input int max_cyc);
        q.delete();
        build(ins, br, rdy_at);
        Instruction  = ins;
        BranchOutput = br;
        play(name, max_cyc);
    endtask

    task automatic test_reset();
        obs_t o, e;
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(negedge Clk);
        e = '0; e.alu = 5'b11111;
        o = sample();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_outputs: got=%h want=%h", o, e);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        ill_m = 1'b0; mf_m = 1'b0;
    endtask

    task automatic test_alu();
        run("add", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 1'b0, 0, 0);
        run("sll", {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000000}, 1'b0, 0, 0);
        run("xori", {6'h0e, 5'd1, 5'd2, 16'h00ff}, 1'b0, 0, 0);
    endtask

    task automatic test_load_store();
        run("lw_wait3", {6'h23, 5'd1, 5'd2, 16'h0010}, 1'b0, 2, 0);
        run("sb", {6'h28, 5'd1, 5'd2, 16'h0004}, 1'b0, 0, 0);
        run("lh_ready_at_timeout", {6'h21, 5'd1, 5'd2, 16'h0002}, 1'b0, MEM_TIMEOUT - 1, 0);
    endtask

    task automatic test_branch();
        run("bne_taken", {6'h05, 5'd1, 5'd2, 16'h0003}, 1'b1, 0, 0);
        run("bne_not_taken", {6'h05, 5'd1, 5'd2, 16'h0003}, 1'b0, 0, 0);
        run("jal", {6'h03, 26'h0000100}, 1'b0, 0, 0);
        run("jr", {6'h00, 5'd31, 15'd0, 6'b001000}, 1'b0, 0, 0);
    endtask

    task automatic test_timeout();
        run("sw_timeout", {6'h2b, 5'd1, 5'd2, 16'h0008}, 1'b0, 1000, 0);
        run("after_timeout", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010}, 1'b0, 0, 0);
    endtask

    task automatic test_mul();
        run("mul", {6'h1c, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000010}, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run("op_3f", {6'h3f, 26'h0}, 1'b0, 0, 0);
        run("rtype_bad_funct", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b111111}, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        obs_t o, e, m;
        run("lw_abort", {6'h23, 5'd1, 5'd2, 16'h0000}, 1'b0, 1000, 4);
        Reset = 1'b1;
        @(negedge Clk);
        o = sample();
        e = '0; e.alu = 5'b11111;
        m = '1; m.st = '0; m.ill = 1'b0; m.mf = 1'b0;
        total++;
        if ((o & m) !== (e & m)) begin
            bad++;
            $display("FAIL reset_mid_mem: got=%h want=%h", o, e);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        ill_m = 1'b0; mf_m = 1'b0;
        run("post_reset_add", {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'b100000}, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int          idx;
        int          rdy;
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 99) < 85) begin
                idx = $urandom_range(0, tbl.size() - 1);
                ins[31:26] = tbl[idx].op;
                if (tbl[idx].fsel == 1) ins[5:0] = tbl[idx].fn;
                if (tbl[idx].fsel == 2) ins[20:16] = tbl[idx].rt;
            end else begin
                for (int k = 0; k < 64 && find(ins) >= 0; k++) ins = $urandom;
            end
            rdy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_TIMEOUT + 3)
                                              : $urandom_range(0, 3);
            run("random", ins, 1'($urandom_range(0, 1)), rdy, 0);
        end
    endtask

    task automatic test_final_fetch();
        step_t s;
        q.delete();
        s = new_step(3'd0); s.e.irw = 1'b1; s.e.pcw = 1'b1;
        q.push_back(s);
        play("final_fetch", 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_timeout();
        test_mul();
        test_illegal();
        test_reset_mid();
        test_random();
        test_final_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
